// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared constants and encodings for the round-robin / directed stream dispatcher.
package demux_rr_dispatcher_pkg;

   localparam int unsigned CH_N  = 4;
   localparam int unsigned SEL_W = 2;

   localparam logic MODE_RR  = 1'b0;
   localparam logic MODE_DIR = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/demux_1to4_param.sv
// 1-to-4 data demux: the selected output carries din, all others are zero.
module demux_1to4_param
   import demux_rr_dispatcher_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] din,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] dout0,
   output logic [WIDTH-1:0] dout1,
   output logic [WIDTH-1:0] dout2,
   output logic [WIDTH-1:0] dout3
);

   always_comb begin
      dout0 = '0;
      dout1 = '0;
      dout2 = '0;
      dout3 = '0;
      case (sel)
         2'd0:    dout0 = din;
         2'd1:    dout1 = din;
         2'd2:    dout2 = din;
         default: dout3 = din;
      endcase
   end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// One-entry holding dispatcher feeding four consumer channels, round-robin or directed.
module demux_rr_dispatcher
   import demux_rr_dispatcher_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic [3:0]       en_mask,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_dest,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic [1:0]       cur_sel,
   output logic             drop_pulse,
   output logic [CNT_W-1:0] drop_cnt
);

   // First enabled channel at or after ptr, wrapping; lowest offset wins.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [SEL_W-1:0] ptr,
                                                input logic [CH_N-1:0]  mask);
      logic [SEL_W-1:0] idx;
      idx     = ptr;
      rr_pick = ptr;
      for (int k = int'(CH_N) - 1; k >= 0; k--) begin
         idx = ptr + SEL_W'(k);
         if (mask[idx]) rr_pick = idx;
      end
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             drop_pulse_q, drop_pulse_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             full;
   logic             fire_out;
   logic             accept;
   logic             drop;
   logic             store;
   logic [SEL_W-1:0] pick;
   logic [WIDTH-1:0] demux_in;

   assign full     = (state_q == ST_HOLD);
   assign fire_out = full & out_ready[sel_q];
   assign in_ready = (~full | fire_out) & ((mode == MODE_DIR) | (|en_mask));
   assign accept   = in_valid & in_ready;
   assign pick     = (mode == MODE_DIR) ? in_dest : rr_pick(rr_ptr_q, en_mask);
   // Directed beats to a disabled channel are consumed but never held.
   assign drop     = accept & (mode == MODE_DIR) & ~en_mask[in_dest];
   assign store    = accept & ~drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         data_q       <= '0;
         sel_q        <= '0;
         rr_ptr_q     <= '0;
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         sel_q        <= sel_d;
         rr_ptr_q     <= rr_ptr_d;
         drop_pulse_q <= drop_pulse_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      sel_d        = sel_q;
      rr_ptr_d     = rr_ptr_q;
      drop_pulse_d = drop;
      drop_cnt_d   = drop_cnt_q;

      case (state_q)
         ST_EMPTY: if (store) state_d = ST_HOLD;
         ST_HOLD:  if (fire_out && !store) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase

      if (store) begin
         data_d = in_data;
         sel_d  = pick;
      end
      if (accept && mode == MODE_RR) rr_ptr_d = pick + SEL_W'(1);
      if (drop && drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   assign demux_in   = full ? data_q : '0;
   assign out_valid  = full ? (CH_N'(1) << sel_q) : '0;
   assign cur_sel    = sel_q;
   assign drop_pulse = drop_pulse_q;
   assign drop_cnt   = drop_cnt_q;

   demux_1to4_param #(.WIDTH(WIDTH)) u_demux (
      .din   (demux_in),
      .sel   (sel_q),
      .dout0 (out_data0),
      .dout1 (out_data1),
      .dout2 (out_data2),
      .dout3 (out_data3)
   );

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Self-checking bench: vector table, directed corner sequences and random traffic vs a reference model.
module tb_demux_rr_dispatcher;

   logic        clk = 1'b0;
   logic        rst, mode, in_valid;
   logic [3:0]  en_mask, out_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_dest;
   logic        in_ready, drop_pulse;
   logic [3:0]  out_valid;
   logic [7:0]  out_data0, out_data1, out_data2, out_data3;
   logic [1:0]  cur_sel;
   logic [15:0] drop_cnt;

   logic        in_ready2, drop_pulse2;
   logic [3:0]  out_valid2;
   logic [7:0]  od2_0, od2_1, od2_2, od2_3;
   logic [1:0]  cur_sel2;
   logic [1:0]  drop_cnt2;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit       m_full;
   bit [7:0] m_data;
   int       m_sel, m_ptr, m_cnt, m_cnt2;
   bit       m_pulse;

   always #5 clk = ~clk;

   demux_rr_dispatcher #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .mode(mode), .en_mask(en_mask), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid),
      .out_ready(out_ready), .out_data0(out_data0), .out_data1(out_data1),
      .out_data2(out_data2), .out_data3(out_data3), .cur_sel(cur_sel),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   demux_rr_dispatcher #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .mode(mode), .en_mask(en_mask), .in_valid(in_valid),
      .in_ready(in_ready2), .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid2),
      .out_ready(out_ready), .out_data0(od2_0), .out_data1(od2_1),
      .out_data2(od2_2), .out_data3(od2_3), .cur_sel(cur_sel2),
      .drop_pulse(drop_pulse2), .drop_cnt(drop_cnt2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [7:0] od [4];
      od[0] = out_data0; od[1] = out_data1; od[2] = out_data2; od[3] = out_data3;
      chk("out_valid", 32'(out_valid), m_full ? (32'd1 << m_sel) : 32'd0);
      chk("cur_sel", 32'(cur_sel), 32'(m_sel));
      for (int i = 0; i < 4; i++)
         chk($sformatf("out_data%0d", i), 32'(od[i]), (m_full && m_sel == i) ? 32'(m_data) : 32'd0);
      chk("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
      chk("drop_cnt_sat", 32'(drop_cnt2), 32'(m_cnt2));
   endtask

   // One clock: drive, check combinational ready, advance model, check registered outputs.
   task automatic cycle(input logic r, input logic md, input logic [3:0] en, input logic v,
                        input logic [1:0] dst, input logic [7:0] d, input logic [3:0] rd,
                        output logic rdy_seen);
      bit fire, exp_rdy, acc, drp;
      int ch;
      rst = r; mode = md; en_mask = en; in_valid = v; in_dest = dst; in_data = d; out_ready = rd;
      #1;
      fire    = m_full && rd[m_sel];
      exp_rdy = (!m_full || fire) && (md || en != 4'd0);
      rdy_seen = in_ready;
      if (!r) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (r) begin
         m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_pulse = 0; m_cnt = 0; m_cnt2 = 0;
      end else begin
         acc = v && exp_rdy;
         drp = 0;
         ch  = 0;
         if (acc) begin
            if (md) begin
               ch  = int'(dst);
               drp = !en[dst];
            end else begin
               for (int k = 0; k < 4; k++) begin
                  if (en[(m_ptr + k) % 4]) begin
                     ch = (m_ptr + k) % 4;
                     break;
                  end
               end
               m_ptr = (ch + 1) % 4;
            end
         end
         m_pulse = drp;
         if (drp) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (acc && !drp) begin
            m_full = 1; m_data = d; m_sel = ch;
         end else if (fire) begin
            m_full = 0;
         end
      end
      #1;
      check_outputs();
   endtask

   typedef struct {
      logic       md;
      logic [3:0] en;
      logic       v;
      logic [1:0] dst;
      logic [7:0] d;
      logic [3:0] rd;
      logic       x_rdy;
      logic [3:0] x_valid;
      logic [1:0] x_sel;
   } vec_t;

   vec_t tbl [14];
   logic rs;

   initial begin
      for (int i = 0; i < 8; i++)
         tbl[i] = '{1'b0, 4'hF, 1'b1, 2'd0, 8'(8'h10 + i), 4'hF, 1'b1, 4'(4'd1 << (i % 4)), 2'(i % 4)};
      tbl[8]  = '{1'b0, 4'hA, 1'b1, 2'd0, 8'h20, 4'hF, 1'b1, 4'b0010, 2'd1};
      tbl[9]  = '{1'b0, 4'hA, 1'b1, 2'd0, 8'h21, 4'hF, 1'b1, 4'b1000, 2'd3};
      tbl[10] = '{1'b0, 4'hA, 1'b1, 2'd0, 8'h22, 4'hF, 1'b1, 4'b0010, 2'd1};
      tbl[11] = '{1'b0, 4'hA, 1'b1, 2'd0, 8'h23, 4'hF, 1'b1, 4'b1000, 2'd3};
      tbl[12] = '{1'b0, 4'h0, 1'b1, 2'd0, 8'h24, 4'hF, 1'b0, 4'b0000, 2'd3};
      tbl[13] = '{1'b0, 4'hF, 1'b1, 2'd0, 8'h30, 4'hF, 1'b1, 4'b0001, 2'd0};

      cycle(1, 0, 4'hF, 0, 0, 8'h00, 4'hF, rs);
      cycle(1, 0, 4'hF, 0, 0, 8'h00, 4'hF, rs);

      // Reset while a beat is held on channel 1 with a non-zero drop count.
      cycle(0, 1, 4'b0111, 1, 2'd3, 8'hEE, 4'hF, rs);
      cycle(0, 0, 4'hF, 1, 0, 8'h66, 4'hF, rs);
      cycle(0, 0, 4'hF, 1, 0, 8'h77, 4'hF, rs);
      cycle(0, 0, 4'hF, 0, 0, 8'h00, 4'h0, rs);
      chk("hold_before_rst", 32'(out_valid), 32'b0010);
      for (int i = 0; i < 3; i++) cycle(1, 0, 4'hF, 1, 0, 8'h99, 4'h0, rs);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_cur_sel", 32'(cur_sel), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("rst_out_data1", 32'(out_data1), 32'd0);

      // Round-robin vectors, then en_mask=0 holding the pointer.
      for (int i = 0; i < 14; i++) begin
         cycle(0, tbl[i].md, tbl[i].en, tbl[i].v, tbl[i].dst, tbl[i].d, tbl[i].rd, rs);
         chk($sformatf("vec%0d_in_ready", i), 32'(rs), 32'(tbl[i].x_rdy));
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].x_valid));
         chk($sformatf("vec%0d_cur_sel", i), 32'(cur_sel), 32'(tbl[i].x_sel));
      end

      // Stall on channel 2 with the producer pushing.
      cycle(0, 1, 4'hF, 1, 2'd2, 8'hA5, 4'hF, rs);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 4'hF, 1, 2'd1, 8'h5A, 4'b1011, rs);
         chk("stall_in_ready", 32'(rs), 32'd0);
         chk("stall_sel", 32'(cur_sel), 32'd2);
         chk("stall_data", 32'(out_data2), 32'hA5);
      end
      cycle(0, 1, 4'hF, 1, 2'd1, 8'h5A, 4'hF, rs);
      chk("unstall_in_ready", 32'(rs), 32'd1);
      chk("unstall_valid", 32'(out_valid), 32'b0010);
      chk("unstall_data", 32'(out_data1), 32'h5A);
      cycle(0, 1, 4'hF, 0, 0, 8'h00, 4'hF, rs);

      // Directed drops and counter saturation.
      cycle(1, 0, 4'hF, 0, 0, 8'h00, 4'hF, rs);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 4'b0111, 1, 2'd3, 8'(8'h40 + i), 4'hF, rs);
         chk("dir_drop_pulse", 32'(drop_pulse), 32'd1);
         chk("dir_no_hold", 32'(out_valid), 32'd0);
      end
      cycle(0, 1, 4'b0111, 1, 2'd0, 8'h44, 4'hF, rs);
      chk("dir_valid", 32'(out_valid), 32'b0001);
      chk("dir_data", 32'(out_data0), 32'h44);
      chk("dir_pulse_off", 32'(drop_pulse), 32'd0);
      chk("dir_cnt", 32'(drop_cnt), 32'd3);
      chk("dir_cnt_sat", 32'(drop_cnt2), 32'd3);
      cycle(0, 1, 4'b0111, 1, 2'd3, 8'h45, 4'hF, rs);
      chk("dir_cnt4", 32'(drop_cnt), 32'd4);
      chk("dir_cnt_sat_hold", 32'(drop_cnt2), 32'd3);
      cycle(0, 1, 4'hF, 0, 0, 8'h00, 4'hF, rs);

      // Mask change while channel 1 is held.
      cycle(1, 0, 4'hF, 0, 0, 8'h00, 4'hF, rs);
      cycle(0, 0, 4'hF, 1, 0, 8'h61, 4'hF, rs);
      cycle(0, 0, 4'hF, 1, 0, 8'h62, 4'hF, rs);
      cycle(0, 0, 4'b0001, 0, 0, 8'h00, 4'h0, rs);
      chk("mask_held_valid", 32'(out_valid), 32'b0010);
      chk("mask_held_data", 32'(out_data1), 32'h62);
      cycle(0, 0, 4'b0001, 1, 0, 8'h63, 4'b0010, rs);
      chk("mask_next_valid", 32'(out_valid), 32'b0001);
      chk("mask_next_data", 32'(out_data0), 32'h63);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
               2'($urandom), 8'($urandom), 4'($urandom), rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
